// File: rtl/mpu_memory_pkg.sv
// Shared types and helpers for the wide multi-word MPU memory.
// Address arithmetic is done at 32 bits and masked back to the configured width.
package mpu_memory_pkg;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

    function automatic int unsigned calc_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    function automatic int unsigned bus_w(input int unsigned words, input int unsigned word_w);
        return words * word_w;
    endfunction

    // (base + offset) mod 2**addr_w; the carry out of the address field is dropped.
    function automatic logic [31:0] wrap_addr(input logic [31:0] base,
                                              input logic [31:0] offset,
                                              input int unsigned addr_w);
        logic [31:0] mask;
        mask = (addr_w >= 32) ? '1 : ((32'd1 << addr_w) - 32'd1);
        return (base + offset) & mask;
    endfunction

endpackage

// File: rtl/mpu_memory_clear.sv
// Post-reset clear sequencer: walks every address once writing zero, then
// parks in READY until the next reset.
module mpu_memory_clear
    import mpu_memory_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        if (state_q == CLEAR) begin
            clr_we = ~sys_rst;
            cnt_d  = cnt_q + ADDR_W'(1);
            if (cnt_q == '1) begin
                state_d = READY;
            end
        end
        // Registered so ready stays low through reset even when no clear is run.
        ready_d = (state_d == READY);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/mpu_memory_wide.sv
// Word-addressed RAM with one unaligned multi-word read port and one multi-word
// write port with per-word enables, write-first bypass and 1- or 2-cycle read latency.
module mpu_memory_wide
    import mpu_memory_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int WORD_W         = 16,
    parameter int RD_WORDS       = 3,
    parameter int WR_WORDS       = 2,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    output logic                         ready,
    input  logic                         re,
    input  logic [ADDR_W-1:0]            r_addr,
    output logic [RD_WORDS*WORD_W-1:0]   r_data,
    output logic                         r_valid,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            w_addr,
    input  logic [WR_WORDS-1:0]          w_en,
    input  logic [WR_WORDS*WORD_W-1:0]   w_data
);

    localparam int unsigned DEPTH = calc_depth(ADDR_W);
    localparam int unsigned RD_W  = bus_w(RD_WORDS, WORD_W);

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              acc_re, acc_we;

    logic [ADDR_W-1:0]   wr_addr [WR_WORDS];
    logic [WR_WORDS-1:0] wr_en;
    logic [ADDR_W-1:0]   rd_addr [RD_WORDS];
    logic [RD_W-1:0]     rd_word;

    logic [RD_W-1:0] dat_p1_d, dat_p1_q;
    logic            vld_p1_d, vld_p1_q;
    logic [RD_W-1:0] r_data_d, r_data_q;
    logic            r_valid_d, r_valid_q;

    mpu_memory_clear #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // User traffic is only honoured once ready and never on a reset edge.
    assign acc_re = re & ready & ~sys_rst;
    assign acc_we = we & ready & ~sys_rst;

    always_comb begin
        for (int j = 0; j < WR_WORDS; j++) begin
            wr_addr[j] = ADDR_W'(wrap_addr(32'(w_addr), 32'(j), ADDR_W));
            wr_en[j]   = acc_we & w_en[j];
        end
    end

    // Write-first bypass per word; ascending j lets the highest write word win.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < RD_WORDS; i++) begin
            rd_addr[i] = ADDR_W'(wrap_addr(32'(r_addr), 32'(i), ADDR_W));
            rd_word[i*WORD_W +: WORD_W] = mem_q[rd_addr[i]];
            for (int j = 0; j < WR_WORDS; j++) begin
                if (wr_en[j] && (wr_addr[j] == rd_addr[i])) begin
                    rd_word[i*WORD_W +: WORD_W] = w_data[j*WORD_W +: WORD_W];
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end
        for (int j = 0; j < WR_WORDS; j++) begin
            if (wr_en[j]) begin
                mem_q[wr_addr[j]] <= w_data[j*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        vld_p1_d = acc_re;
        dat_p1_d = acc_re ? rd_word : dat_p1_q;
        if (READ_LAT >= 2) begin
            r_valid_d = vld_p1_q;
            r_data_d  = vld_p1_q ? dat_p1_q : r_data_q;
        end else begin
            r_valid_d = acc_re;
            r_data_d  = acc_re ? rd_word : r_data_q;
        end
    end

    // Stage p1: captured read word, only used for the two-cycle latency.
    always_ff @(posedge sys_clk) begin
        dat_p1_q <= dat_p1_d;
    end

    // Output stage: r_data holds between results and clears on reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vld_p1_q  <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
        end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;

endmodule

// File: tb/tb_mpu_memory_wide.sv
// Directed bench for mpu_memory_wide: two instances (read latency 1 and 2)
// share one stimulus stream so their contents stay identical.
module tb_mpu_memory_wide;

    localparam int AW = 4;
    localparam int WW = 16;
    localparam int RW = 3;
    localparam int WRW = 2;

    logic                sys_clk = 1'b0;
    logic                sys_rst;
    logic                re, we;
    logic [AW-1:0]       r_addr, w_addr;
    logic [WRW-1:0]      w_en;
    logic [WRW*WW-1:0]   w_data;
    logic                ready1, ready2, r_valid1, r_valid2;
    logic [RW*WW-1:0]    r_data1, r_data2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    mpu_memory_wide #(.ADDR_W(AW), .WORD_W(WW), .RD_WORDS(RW), .WR_WORDS(WRW),
                      .READ_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ready(ready1), .re(re), .r_addr(r_addr),
        .r_data(r_data1), .r_valid(r_valid1), .we(we), .w_addr(w_addr), .w_en(w_en),
        .w_data(w_data));

    mpu_memory_wide #(.ADDR_W(AW), .WORD_W(WW), .RD_WORDS(RW), .WR_WORDS(WRW),
                      .READ_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ready(ready2), .re(re), .r_addr(r_addr),
        .r_data(r_data2), .r_valid(r_valid2), .we(we), .w_addr(w_addr), .w_en(w_en),
        .w_data(w_data));

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Counts 16 edges after reset release; ready must stay low until the last.
    task automatic wait_clear(input string tag);
        int early = 0;
        int vld   = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16 && (ready1 !== 1'b0 || ready2 !== 1'b0)) early++;
            if (r_valid1 !== 1'b0 || r_valid2 !== 1'b0) vld++;
        end
        n_tests++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL %s_ready_early: ready high on %0d edges, required 0", tag, early);
        end
        n_tests++;
        if (ready1 !== 1'b1 || ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_rise: ready=%b/%b after 16 edges, required 1/1", tag, ready1, ready2);
        end
        n_tests++;
        if (vld != 0) begin
            n_fail++;
            $display("FAIL %s_valid_in_clear: r_valid seen on %0d edges, required 0", tag, vld);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step();
        step();
        n_tests++;
        if (ready1 !== 1'b0 || r_valid1 !== 1'b0 || r_data1 !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b r_valid=%b r_data=%h, required 0 0 0", ready1, r_valid1, r_data1);
        end
        sys_rst = 1'b0;
        wait_clear("clear");
        re = 1'b1; r_addr = 4'd9;
        step();
        re = 1'b0;
        n_tests++;
        if (r_valid1 !== 1'b1 || r_data1 !== 48'h0000_0000_0000) begin
            n_fail++;
            $display("FAIL clear_read9: r_valid=%b r_data=%h, required 1 000000000000", r_valid1, r_data1);
        end
    endtask

    task automatic test_basic();
        we = 1'b1; w_addr = 4'd4; w_en = 2'b11; w_data = 32'hBBBB_AAAA;
        step();
        we = 1'b0; re = 1'b1; r_addr = 4'd4;
        step();
        re = 1'b0;
        n_tests++;
        if (r_valid1 !== 1'b1 || r_data1 !== 48'h0000_BBBB_AAAA) begin
            n_fail++;
            $display("FAIL basic_read4: r_valid=%b r_data=%h, required 1 0000bbbbaaaa", r_valid1, r_data1);
        end
        step();
        n_tests++;
        if (r_valid1 !== 1'b0 || r_data1 !== 48'h0000_BBBB_AAAA) begin
            n_fail++;
            $display("FAIL basic_pulse_hold: r_valid=%b r_data=%h, required 0 0000bbbbaaaa", r_valid1, r_data1);
        end
    endtask

    task automatic test_wrap();
        we = 1'b1; w_addr = 4'd15; w_en = 2'b11; w_data = 32'h2222_1111;
        step();
        we = 1'b0; re = 1'b1; r_addr = 4'd14;
        step();
        re = 1'b0;
        n_tests++;
        if (r_valid1 !== 1'b1 || r_data1 !== 48'h2222_1111_0000) begin
            n_fail++;
            $display("FAIL wrap_read14: r_valid=%b r_data=%h, required 1 222211110000", r_valid1, r_data1);
        end
    endtask

    task automatic test_collision();
        we = 1'b1; w_addr = 4'd5; w_en = 2'b01; w_data = 32'h4444_3333;
        re = 1'b1; r_addr = 4'd4;
        step();
        we = 1'b0; r_addr = 4'd6;
        n_tests++;
        if (r_valid1 !== 1'b1 || r_data1 !== 48'h0000_3333_AAAA) begin
            n_fail++;
            $display("FAIL collision_bypass: r_valid=%b r_data=%h, required 1 00003333aaaa", r_valid1, r_data1);
        end
        step();
        re = 1'b0;
        n_tests++;
        if (r_data1 !== 48'h0000_0000_0000) begin
            n_fail++;
            $display("FAIL collision_masked_word: r_data=%h, required 000000000000", r_data1);
        end
        // A write with no enables must leave memory untouched.
        we = 1'b1; w_addr = 4'd8; w_en = 2'b00; w_data = 32'hFFFF_FFFF;
        step();
        we = 1'b0; re = 1'b1; r_addr = 4'd7;
        step();
        re = 1'b0;
        n_tests++;
        if (r_valid1 !== 1'b1 || r_data1 !== 48'h0000_0000_0000) begin
            n_fail++;
            $display("FAIL noop_write: r_valid=%b r_data=%h, required 1 000000000000", r_valid1, r_data1);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] exp [3];
        logic [3:0]  adr [3];
        exp[0] = 48'h0000_3333_AAAA; adr[0] = 4'd4;
        exp[1] = 48'h2222_1111_0000; adr[1] = 4'd14;
        exp[2] = 48'h0000_0000_2222; adr[2] = 4'd0;
        step();
        for (int k = 0; k < 3; k++) begin
            re = 1'b1; r_addr = adr[k];
            step();
            n_tests++;
            if (r_valid1 !== 1'b1 || r_data1 !== exp[k]) begin
                n_fail++;
                $display("FAIL pipe_lat1_%0d: r_valid=%b r_data=%h, required 1 %h", k, r_valid1, r_data1, exp[k]);
            end
            n_tests++;
            if (k == 0 ? (r_valid2 !== 1'b0) : (r_valid2 !== 1'b1 || r_data2 !== exp[k-1])) begin
                n_fail++;
                $display("FAIL pipe_lat2_%0d: r_valid=%b r_data=%h", k, r_valid2, r_data2);
            end
        end
        re = 1'b0;
        step();
        n_tests++;
        if (r_valid1 !== 1'b0 || r_valid2 !== 1'b1 || r_data2 !== exp[2]) begin
            n_fail++;
            $display("FAIL pipe_tail: r_valid=%b/%b r_data2=%h, required 0/1 %h", r_valid1, r_valid2, r_data2, exp[2]);
        end
        step();
        n_tests++;
        if (r_valid2 !== 1'b0 || r_data2 !== exp[2]) begin
            n_fail++;
            $display("FAIL pipe_lat2_end: r_valid=%b r_data=%h, required 0 %h", r_valid2, r_data2, exp[2]);
        end
    endtask

    task automatic test_reset_mid_op();
        re = 1'b1; r_addr = 4'd4;
        step();
        sys_rst = 1'b1; re = 1'b0;
        step();
        n_tests++;
        if (r_valid1 !== 1'b0 || r_valid2 !== 1'b0 || ready1 !== 1'b0 || ready2 !== 1'b0 || r_data1 !== 48'h0) begin
            n_fail++;
            $display("FAIL midop_reset: r_valid=%b/%b ready=%b/%b r_data=%h, required 0/0 0/0 0",
                     r_valid1, r_valid2, ready1, ready2, r_data1);
        end
        step();
        n_tests++;
        if (r_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_lat2_flush: r_valid=%b, required 0", r_valid2);
        end
        sys_rst = 1'b0;
        re = 1'b1; r_addr = 4'd4;
        we = 1'b1; w_addr = 4'd4; w_en = 2'b11; w_data = 32'hFFFF_FFFF;
        wait_clear("reclear");
        re = 1'b0; we = 1'b0;
        step();
        re = 1'b1; r_addr = 4'd4;
        step();
        re = 1'b0;
        n_tests++;
        if (r_valid1 !== 1'b1 || r_data1 !== 48'h0000_0000_0000) begin
            n_fail++;
            $display("FAIL reclear_read4: r_valid=%b r_data=%h, required 1 000000000000", r_valid1, r_data1);
        end
        step();
        n_tests++;
        if (r_valid2 !== 1'b1 || r_data2 !== 48'h0000_0000_0000) begin
            n_fail++;
            $display("FAIL reclear_read4_lat2: r_valid=%b r_data=%h, required 1 000000000000", r_valid2, r_data2);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        re = 1'b0; we = 1'b0;
        r_addr = '0; w_addr = '0; w_en = '0; w_data = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_collision();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
